// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory fetch controller.
package imem_pkg;

   typedef enum logic [1:0] {
      FETCH = 2'd0,
      DRAIN = 2'd1,
      HOLD  = 2'd2,
      LOAD  = 2'd3
   } fetch_state_e;

   localparam int unsigned BYTES_PER_INST = 4;
   localparam int unsigned DEF_ADDR_W     = 16;
   localparam logic [31:0] DEF_RESET_PC   = 32'h0000_0000;

   // Bit offset of byte lane idx inside a big-endian instruction word.
   function automatic int unsigned lane_lsb(input logic [1:0] idx);
      return (BYTES_PER_INST - 1 - int'(idx)) * 8;
   endfunction

endpackage

// File: rtl/imem_fetch_ctrl_if.sv
// Bundle of memory, loader, redirect and decode-side signals of the fetch controller.
interface imem_fetch_ctrl_if
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W = DEF_ADDR_W
);

   logic [ADDR_W-1:0] mem_addr;
   logic              mem_rd_en;
   logic [7:0]        mem_rdata;
   logic              mem_wr_en;
   logic [7:0]        mem_wdata;
   logic              ld_valid;
   logic              ld_ready;
   logic [ADDR_W-1:0] ld_addr;
   logic [7:0]        ld_data;
   logic              redirect;
   logic [31:0]       redirect_pc;
   logic              inst_valid;
   logic              inst_ready;
   logic [31:0]       inst;
   logic [31:0]       inst_pc;
   logic              busy;

   modport master (
      output mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      output ld_ready, inst_valid, inst, inst_pc, busy,
      input  mem_rdata, ld_valid, ld_addr, ld_data,
      input  redirect, redirect_pc, inst_ready
   );

   modport slave (
      input  mem_addr, mem_rd_en, mem_wr_en, mem_wdata,
      input  ld_ready, inst_valid, inst, inst_pc, busy,
      output mem_rdata, ld_valid, ld_addr, ld_data,
      output redirect, redirect_pc, inst_ready
   );

endinterface

// File: rtl/imem_fetch_ctrl_assembler.sv
// Byte-capture register building a 32-bit big-endian instruction from 4 memory bytes.
module inst_byte_assembler
   import imem_pkg::*;
(
   input  logic        clk,
   input  logic        clear,
   input  logic        cap_en,
   input  logic [1:0]  cap_idx,
   input  logic [7:0]  byte_in,
   output logic [31:0] word
);

   // Clear has priority; otherwise write the addressed lane when capture is enabled.
   always_ff @(posedge clk) begin
      if (clear) begin
         word <= '0;
      end else if (cap_en) begin
         word[lane_lsb(cap_idx) +: 8] <= byte_in;
      end
   end

endmodule

// File: rtl/imem_fetch_ctrl.sv
// Byte-wide instruction fetch controller with redirect and memory-loader arbitration.
module imem_fetch_ctrl
   import imem_pkg::*;
#(
   parameter int unsigned ADDR_W   = DEF_ADDR_W,
   parameter logic [31:0] RESET_PC = DEF_RESET_PC
) (
   input logic               clk,
   input logic               rst,
   imem_fetch_ctrl_if.master bus
);

   fetch_state_e state;
   logic [1:0]   k;
   logic [31:0]  pc;
   logic         inst_valid_q;
   logic [31:0]  inst_pc_q;
   logic         cap_en;
   logic [1:0]   cap_idx;
   logic         wr_fire;
   logic [31:0]  asm_word;

   // Byte from the read issued last cycle lands in lane k-1; DRAIN takes the last lane.
   always_comb begin
      cap_en  = 1'b0;
      cap_idx = k - 2'd1;
      if (state == FETCH && k != 2'd0) begin
         cap_en = 1'b1;
      end else if (state == DRAIN) begin
         cap_en  = 1'b1;
         cap_idx = 2'd3;
      end
   end

   inst_byte_assembler u_asm (
      .clk     (clk),
      .clear   (rst),
      .cap_en  (cap_en),
      .cap_idx (cap_idx),
      .byte_in (bus.mem_rdata),
      .word    (asm_word)
   );

   // Memory strobes are gated by rst so nothing reaches memory in a reset cycle.
   assign wr_fire       = (state == LOAD) && bus.ld_valid && !rst;
   assign bus.mem_rd_en = (state == FETCH) && !rst;
   assign bus.mem_wr_en = wr_fire;
   assign bus.mem_wdata = wr_fire ? bus.ld_data : '0;
   assign bus.mem_addr  = (state == LOAD) ? bus.ld_addr : pc[ADDR_W-1:0] + ADDR_W'(k);
   assign bus.ld_ready  = (state == LOAD) && !rst;
   assign bus.busy      = (state == FETCH || state == DRAIN) && !rst;
   assign bus.inst_valid = inst_valid_q;
   assign bus.inst      = asm_word;
   assign bus.inst_pc   = inst_pc_q;

   // Fetch FSM: redirect beats loader grant; loader is granted only at k=0 or in HOLD.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         k            <= '0;
         pc           <= RESET_PC;
         inst_valid_q <= 1'b0;
         inst_pc_q    <= '0;
      end else begin
         unique case (state)
            FETCH: begin
               if (bus.redirect) begin
                  pc <= bus.redirect_pc;
                  k  <= '0;
               end else if (k == 2'd0 && bus.ld_valid) begin
                  state <= LOAD;
               end else if (k == 2'd3) begin
                  state <= DRAIN;
                  k     <= '0;
               end else begin
                  k <= k + 2'd1;
               end
            end
            DRAIN: begin
               if (bus.redirect) begin
                  pc    <= bus.redirect_pc;
                  state <= FETCH;
                  k     <= '0;
               end else begin
                  state        <= HOLD;
                  inst_valid_q <= 1'b1;
                  inst_pc_q    <= pc;
               end
            end
            HOLD: begin
               if (bus.redirect) begin
                  // Covers redirect coinciding with accept: the new pc wins over pc+4.
                  pc           <= bus.redirect_pc;
                  state        <= FETCH;
                  k            <= '0;
                  inst_valid_q <= 1'b0;
               end else if (bus.ld_valid) begin
                  if (bus.inst_ready) begin
                     pc <= pc + BYTES_PER_INST;
                  end
                  state        <= LOAD;
                  inst_valid_q <= 1'b0;
               end else if (bus.inst_ready) begin
                  pc           <= pc + BYTES_PER_INST;
                  state        <= FETCH;
                  k            <= '0;
                  inst_valid_q <= 1'b0;
               end
            end
            LOAD: begin
               if (bus.redirect) begin
                  pc <= bus.redirect_pc;
               end
               if (!bus.ld_valid) begin
                  state <= FETCH;
                  k     <= '0;
               end
            end
            default: begin
               state <= FETCH;
               k     <= '0;
            end
         endcase
      end
   end

endmodule
